// File: rtl/dreq_credits_wr_mc_if.sv
// ----------------------------------------------------------------------------
// dreq_credits_wr_mc_if
// Request bus bundle around the multi-channel write-request credit gate.
// Upstream side: per-channel request valid/ready/data.
// Downstream side: a single request valid/ready/data plus its source channel.
//   slave  : view of the credit gate itself (takes requests, drives output)
//   master : view of the surrounding logic (issues requests, takes output)
// ----------------------------------------------------------------------------
interface dreq_credits_wr_mc_if #(
  parameter int unsigned N_CHAN    = 4,
  parameter int unsigned REQ_BITS  = 64,
  parameter int unsigned CHAN_BITS = 2
);
  logic [N_CHAN-1:0]          s_req_valid;
  logic [N_CHAN-1:0]          s_req_ready;
  logic [N_CHAN*REQ_BITS-1:0] s_req_data;
  logic                       m_req_valid;
  logic                       m_req_ready;
  logic [REQ_BITS-1:0]        m_req_data;
  logic [CHAN_BITS-1:0]       m_req_chan;

  modport slave (
    input  s_req_valid, s_req_data, m_req_ready,
    output s_req_ready, m_req_valid, m_req_data, m_req_chan
  );

  modport master (
    output s_req_valid, s_req_data, m_req_ready,
    input  s_req_ready, m_req_valid, m_req_data, m_req_chan
  );
endinterface

// File: rtl/dreq_credits_wr_mc.sv
// ----------------------------------------------------------------------------
// dreq_credits_wr_mc
// Per-channel beat-credit gate for write requests. A request is only released
// once its channel has buffered enough write-data beats to cover the whole
// transfer; eligible requests are round-robin arbitrated into one registered
// output slot ahead of the shared write DMA.
//
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset
//   bus            request bundle (slave modport): s_req_* per channel in,
//                  m_req_* single registered request out, m_req_chan source
//   xfer           one write-data beat buffered for channel i this cycle
//   cnt_ovf        sticky per-channel credit counter saturation flag
//   stat_req       (DREQ_CREDITS_WR_STATS_EN) granted requests per channel
//   stat_stall     (DREQ_CREDITS_WR_STATS_EN) valid-but-starved cycles
//
// Optional feature macro: DREQ_CREDITS_WR_STATS_EN
// ----------------------------------------------------------------------------
module dreq_credits_wr_mc #(
  parameter int unsigned N_CHAN    = 4,
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned REQ_BITS  = 64,
  parameter int unsigned LEN_OFFS  = 0,
  parameter int unsigned LEN_BITS  = 28,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  dreq_credits_wr_mc_if.slave      bus,
  input  logic [N_CHAN-1:0]        xfer,
  output logic [N_CHAN-1:0]        cnt_ovf
`ifdef DREQ_CREDITS_WR_STATS_EN
  ,
  output logic [N_CHAN*32-1:0]     stat_req,
  output logic [N_CHAN*32-1:0]     stat_stall
`endif
);

  localparam int unsigned BEAT_BYTES = DATA_BITS / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned CHAN_BITS  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned NB_BITS    = CNT_BITS + 1;
  localparam int unsigned WIDE       = (LEN_BITS + 1 > NB_BITS) ? LEN_BITS + 1 : NB_BITS;
  localparam logic [WIDE-1:0]     NB_MAX  = (WIDE'(1) << NB_BITS) - WIDE'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0]  r_cnt [N_CHAN];
  logic [N_CHAN-1:0]    r_ovf;
  logic [CHAN_BITS-1:0] r_ptr;
  logic                 r_m_valid;
  logic [REQ_BITS-1:0]  r_m_data;
  logic [CHAN_BITS-1:0] r_m_chan;

  logic [NB_BITS-1:0]   w_nb [N_CHAN];
  logic [CNT_BITS-1:0]  w_cnt_n [N_CHAN];
  logic [N_CHAN-1:0]    w_elig;
  logic [N_CHAN-1:0]    w_grant;
  logic [N_CHAN-1:0]    w_ovf_set;
  logic                 w_found;
  logic                 w_load;
  logic [CHAN_BITS-1:0] w_gidx;

  // Beats needed per request (rounded up); clamped into NB_BITS, which still
  // exceeds any counter value, so oversized requests simply never qualify.
  always_comb begin : p_beats
    logic [WIDE-1:0] v_nb;
    v_nb   = '0;
    w_elig = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      v_nb = (WIDE'(bus.s_req_data[i*REQ_BITS + LEN_OFFS +: LEN_BITS])
              + WIDE'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
      w_nb[i]   = (v_nb > NB_MAX) ? '1 : NB_BITS'(v_nb);
      w_elig[i] = bus.s_req_valid[i] && (NB_BITS'(r_cnt[i]) >= w_nb[i]);
    end
  end

  // Round-robin pick starting at r_ptr; only loads when the slot is free or draining.
  always_comb begin : p_arb
    int unsigned v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      v_idx = (32'(r_ptr) + 32'(k)) % N_CHAN;
      if (!w_found && w_elig[CHAN_BITS'(v_idx)]) begin
        w_found = 1'b1;
        w_gidx  = CHAN_BITS'(v_idx);
      end
    end
    w_load  = (!r_m_valid || bus.m_req_ready) && w_found;
    w_grant = '0;
    if (w_load) w_grant[w_gidx] = 1'b1;
  end

  // Credit update nets beat arrival against grant; saturates at CNT_MAX.
  always_comb begin : p_cnt_next
    logic [NB_BITS-1:0] v_sum;
    v_sum     = '0;
    w_cnt_n   = r_cnt;
    w_ovf_set = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      v_sum = NB_BITS'(r_cnt[i]) + NB_BITS'(xfer[i]) - (w_grant[i] ? w_nb[i] : '0);
      if (v_sum > NB_BITS'(CNT_MAX)) begin
        w_cnt_n[i]   = CNT_MAX;
        w_ovf_set[i] = 1'b1;
      end else begin
        w_cnt_n[i]   = CNT_BITS'(v_sum);
      end
    end
  end

  // Credit counters, RR pointer and the output request slot.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CHAN; i++) r_cnt[i] <= '0;
      r_ovf     <= '0;
      r_ptr     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_chan  <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) r_cnt[i] <= w_cnt_n[i];
      r_ovf <= r_ovf | w_ovf_set;
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= bus.s_req_data[32'(w_gidx)*REQ_BITS +: REQ_BITS];
        r_m_chan  <= w_gidx;
        r_ptr     <= (w_gidx == CHAN_BITS'(N_CHAN - 1)) ? '0 : w_gidx + CHAN_BITS'(1);
      end else if (bus.m_req_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.s_req_ready = w_grant;
  assign bus.m_req_valid = r_m_valid;
  assign bus.m_req_data  = r_m_data;
  assign bus.m_req_chan  = r_m_chan;
  assign cnt_ovf         = r_ovf;

`ifdef DREQ_CREDITS_WR_STATS_EN
  logic [31:0] r_stat_req   [N_CHAN];
  logic [31:0] r_stat_stall [N_CHAN];

  // Free-running wrap-around statistics per channel.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CHAN; i++) begin
        r_stat_req[i]   <= '0;
        r_stat_stall[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (w_grant[i]) r_stat_req[i] <= r_stat_req[i] + 32'd1;
        if (bus.s_req_valid[i] && !w_elig[i]) r_stat_stall[i] <= r_stat_stall[i] + 32'd1;
      end
    end
  end

  always_comb begin : p_stat_pack
    stat_req   = '0;
    stat_stall = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      stat_req[i*32 +: 32]   = r_stat_req[i];
      stat_stall[i*32 +: 32] = r_stat_stall[i];
    end
  end
`endif

endmodule

// File: doc/dreq_credits_wr_mc.md
Name: dreq_credits_wr_mc

Overview:
Multi-channel, parametrised credit gate for write requests. Each of N_CHAN request channels has its own beat-credit counter, incremented by that channel's write-data beats (xfer). A request is released only when its channel holds enough buffered beats to cover the whole transfer, so a stalled region cannot block the shared write path. Eligible requests are round-robin arbitrated onto a single registered output placed ahead of the shared write DMA.

Parameters:
N_CHAN, 4, number of request channels (1..16)
DATA_BITS, AXI_DATA_BITS, write data bus width; BEAT_BYTES = DATA_BITS/8 (power of 2)
REQ_BITS, $bits(dreq_t), width of one request word
LEN_OFFS, 0, bit offset of the length field within a request word
LEN_BITS, 28, width of the length field (bytes)
CNT_BITS, 16, width of each per-channel credit counter

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous, active-low reset
s_req_valid  in  N_CHAN  per-channel request valid
s_req_ready  out  N_CHAN  per-channel request accept
s_req_data  in  N_CHAN*REQ_BITS  per-channel request word; channel i occupies bits [i*REQ_BITS +: REQ_BITS]
xfer  in  N_CHAN  one write-data beat buffered for channel i this cycle
m_req_valid  out  1  registered output request valid
m_req_ready  in  1  downstream accept
m_req_data  out  REQ_BITS  registered output request word
m_req_chan  out  max(1,$clog2(N_CHAN))  source channel of m_req_data
cnt_ovf  out  N_CHAN  sticky: channel credit counter saturated

Behaviour:
- Reset (aresetn=0 at posedge aclk): all counters 0, RR pointer 0, m_req_valid=0, m_req_data=0, m_req_chan=0, cnt_ovf=0. s_req_ready is 0 while the output register is full and not being drained.
- Beats required: n_beats[i] = (len[i] + BEAT_BYTES-1) >> log2(BEAT_BYTES), i.e. rounded up. Computed at CNT_BITS+1 width so that it cannot wrap.
- Eligibility: elig[i] = s_req_valid[i] && (cnt[i] >= n_beats[i]). A zero-length request needs 0 beats, is always eligible, and consumes no credit.
- Output stage: single register. load = (!m_req_valid || m_req_ready) && |elig.
- Arbitration: round-robin, starting the search at the RR pointer. The granted channel g gets s_req_ready[g]=1 in the same cycle as load. All other channels' s_req_ready are 0. On load, the pointer becomes (g+1) mod N_CHAN. The pointer is unchanged when there is no grant.
- Latency: eligible at cycle t, m_req_valid=1 at t+1. With m_req_ready held high, throughput is one request per cycle.
- Output hold: m_req_data and m_req_chan hold stable while m_req_valid && !m_req_ready. m_req_valid falls after acceptance when there is no new load.
- Counter update (per channel, same cycle): cnt_N = cnt + xfer[i] - (grant[i] ? n_beats[i] : 0). A simultaneous xfer and grant nets both.
- Credits never go negative; eligibility guarantees this.
- Saturation: if cnt = 2^CNT_BITS-1 and the net update would increment, the counter holds at max and cnt_ovf[i] is set. cnt_ovf[i] stays set until reset.
- s_req_ready is asserted combinationally from s_req_valid, the counters and m_req_ready. It does not depend combinationally on xfer, so a beat arriving in the same cycle does not enable a grant until the next cycle.
- N_CHAN=1 degenerates to a single-channel gate; m_req_chan is tied to 0.
- A reset mid-operation drops the pending output request and clears all credits. Upstream must also reset its data buffers.

Optional Feature:
Macro: DREQ_CREDITS_WR_STATS_EN
- Defined: adds output ports stat_req (N_CHAN*32) and stat_stall (N_CHAN*32).
  - stat_req counts granted requests per channel.
  - stat_stall counts cycles where s_req_valid[i] && cnt[i] < n_beats[i].
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. DATA_BITS=512. Ch0 request with len=256 (4 beats); send 3 xfer -> no grant. 4th xfer -> s_req_ready[0] the next cycle, m_req_valid one cycle later, cnt[0]=0.
2. Ch1 request with len=100 (rounds up to 2 beats) and 2 beats buffered -> granted; cnt[1] goes from 2 to 0. With 1 beat buffered -> no grant.
3. All 4 channels eligible, m_req_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; m_req_chan follows 0,1,2,3; pointer returns to 0.
4. m_req_ready=0 for 5 cycles with a request in the output register -> m_req_data stable, all s_req_ready=0, credits keep accruing from xfer.
5. cnt[2]=3, grant of a 3-beat request and xfer[2]=1 in the same cycle -> cnt[2]=1. A zero-length request with cnt=0 -> granted, cnt unchanged.
6. CNT_BITS=4: 16 xfers with no requests -> cnt holds at 15 and cnt_ovf[0]=1. Assert reset -> cnt=0, cnt_ovf=0, m_req_valid=0.
